// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer: in_ready and out_valid depend
// only on registered occupancy and stall. Stall holds the stage; flush empties it.
//
// state   | {m_vld,s_vld} | meaning
// --------+---------------+-------------------------------------------
// EMPTY   | 00            | nothing held, in_ready high unless stalled
// ONE     | 10            | main register holds the oldest entry
// FULL    | 11            | skid holds a younger entry, in_ready low
module pipe_skid_reg #(
   parameter int                DATA_W         = 96,
   parameter logic [DATA_W-1:0] RST_VAL        = '0,
   parameter bit                CLEAR_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_m_data;
   logic [DATA_W-1:0] r_s_data;

   logic w_m_vld;
   logic w_s_vld;
   logic w_push;
   logic w_pop;
   logic w_m_ld_in;
   logic w_m_ld_skid;
   logic w_s_ld_in;
   logic w_clr;

   // The state encoding is the valid-bit pair, so occupancy and ready come straight off flops.
   assign w_m_vld   = r_state[1];
   assign w_s_vld   = r_state[0];

   assign in_ready  = ~w_s_vld & ~stall;
   assign out_valid = w_m_vld & ~stall;
   assign occupancy = {1'b0, w_m_vld} + {1'b0, w_s_vld};
   assign out_data  = r_m_data;

   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_m_ld_in   = 1'b0;
      w_m_ld_skid = 1'b0;
      w_s_ld_in   = 1'b0;
      w_clr       = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_clr       = CLEAR_ON_FLUSH;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_state_nxt = ST_ONE;
                  w_m_ld_in   = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  w_m_ld_in   = 1'b1;
               end else if (w_push) begin
                  w_state_nxt = ST_FULL;
                  w_s_ld_in   = 1'b1;
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  w_state_nxt = ST_ONE;
                  w_m_ld_skid = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // Payload flops are enabled only on real transfers so idle cycles cost no data toggling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m_data <= RST_VAL;
         r_s_data <= RST_VAL;
      end else if (w_clr) begin
         r_m_data <= RST_VAL;
         r_s_data <= RST_VAL;
      end else begin
         if (w_m_ld_in) begin
            r_m_data <= in_data;
         end else if (w_m_ld_skid) begin
            r_m_data <= r_s_data;
         end
         if (w_s_ld_in) begin
            r_s_data <= in_data;
         end
      end
   end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register, the successor to the fixed-field inter-stage registers between decode, execute and memory. It carries an opaque `DATA_W`-bit payload (the concatenated stage bundle) under a valid/ready handshake. A two-entry skid buffer keeps the upstream `in_ready` a pure register output, so no combinational ready path crosses the stage. The block also supports a global stall, a flush that kills in-flight entries, and an occupancy output for hazard and performance logic.

## Interface
- `DATA_W`, 96: payload width in bits (≥1).
- `RST_VAL`, 0: `DATA_W`-bit value loaded into both payload registers on reset.
- `CLEAR_ON_FLUSH`, 1: 1 = flush also loads `RST_VAL` into the payload registers; 0 = payload registers keep their contents and only the valid bits clear.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `stall`  in  1  global hold: no transfer on either side while high.
- `flush`  in  1  kill all held entries; any input offered in the same cycle is discarded.
- `in_valid`  in  1  upstream has a payload.
- `in_ready`  out  1  stage can accept a payload.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  downstream payload valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  downstream payload; always driven from the main register.
- `occupancy`  out  2  entries held: 0, 1 or 2.

## Operation
- **Storage.** Main register `m_data`/`m_vld` drives the output. Skid register `s_data`/`s_vld` holds one overflow entry. The invariant `s_vld ⇒ m_vld` always holds.
- **Transfers.**
  - `push = in_valid & in_ready`
  - `pop = out_valid & out_ready`
- **Combinational outputs.**
  - `in_ready = ~s_vld & ~stall`
  - `out_valid = m_vld & ~stall`
  - `occupancy = m_vld + s_vld`
- **States.** Encoded by {`m_vld`, `s_vld`}: EMPTY (00), ONE (10), FULL (11).
- **Transitions** (when `flush` = 0):
  - EMPTY: `push` → ONE, `m_data <= in_data`. Otherwise hold.
  - ONE:
    - `push & pop` → ONE, `m_data <= in_data`.
    - `push & ~pop` → FULL, `s_data <= in_data`.
    - `~push & pop` → EMPTY.
    - Otherwise hold.
  - FULL: `in_ready` = 0, so no push is possible. `pop` → ONE, `m_data <= s_data`. Otherwise hold.
- **Ordering.** Strict FIFO. The skid entry is always younger than the main entry.
- **Stall.**
  - Forces `in_ready` = 0 and `out_valid` = 0, so neither `push` nor `pop` can occur.
  - All state holds.
  - `out_data` still shows `m_data`.
- **Flush.**
  - Next edge: `m_vld` = `s_vld` = 0, regardless of `stall`, `push` or `pop` that cycle.
  - If `CLEAR_ON_FLUSH` = 1, both payload registers load `RST_VAL`.
  - Any upstream handshake seen that cycle is discarded. Upstream must treat it as consumed-and-killed.
- **Priority:** `rst_n` low > `flush` > `stall` > normal transitions.
- **Payload registers** load only on the transitions listed above. They never load on idle cycles, to save power.

## Timing
- **Reset** (`rst_n` = 0 at an edge):
  - `m_vld` = `s_vld` = 0.
  - `m_data` = `s_data` = `RST_VAL`.
- **Output values after reset:**
  - `out_valid` = 0.
  - `in_ready` = 1 if `stall` = 0, else 0.
  - `out_data` = `RST_VAL`.
  - `occupancy` = 0.
- **Reset mid-operation:** held entries are lost. No partial state survives.
- **Latency:** a `push` at edge N makes the payload visible on `out_data` with `out_valid` = 1 in cycle N+1. There is no combinational path from `in_*` to `out_*`.
- **Throughput:** one payload per cycle while `out_ready` = 1.
- **Back-pressure:**
  - `in_ready` falls one cycle after the stage becomes FULL.
  - It rises one cycle after the pop that leaves ONE.
  - It depends only on registered state and `stall`.
- **Allowed combinational paths:**
  - `out_ready` → `in_ready`: none.
  - `stall` → both ready/valid outputs.
- **Simultaneous push and pop in ONE:** occupancy stays 1 and the new payload replaces the popped one.
- **Pop in FULL:** the skid entry moves to main in the same edge.
- **Flush while FULL with `pop` = 1:** the downstream handshake completes. The entry is delivered, then both entries are cleared.

## Test plan
- **Reset and first push.** Hold `rst_n` = 0 for 2 cycles, `RST_VAL` = 0. Then push `in_data` = 0x0A at edge 1 with `out_ready` = 1. Required: `out_valid` = 0 and `occupancy` = 0 before edge 1; `out_data` = 0x0A and `out_valid` = 1 in the cycle after edge 1.
- **Streaming.** `out_ready` = 1, push 0x01..0x10 on consecutive cycles. Required: identical sequence out, one per cycle, latency 1, `in_ready` constantly 1.
- **Skid fill and drain.** Push 0x11 and 0x22 with `out_ready` = 0. Required: `occupancy` = 2 and `in_ready` = 0, with `out_data` = 0x11 held. Then raise `out_ready`. Required: 0x11, then 0x22, on consecutive cycles; `in_ready` = 1 after the first pop.
- **Stall.** Stall for 3 cycles while FULL with `out_ready` = 1. Required: `out_valid` = 0, `in_ready` = 0, no data loss. After release: 0x11, then 0x22.
- **Flush.** Flush while FULL and `in_valid` = 1 offering 0x33. Required next cycle: `occupancy` = 0, `out_valid` = 0, `out_data` = `RST_VAL`. 0x33 never appears on `out_data`.
- **Width sweep.** Repeat the skid fill and drain scenario with `DATA_W` = 1 and 128 and `CLEAR_ON_FLUSH` = 0. Required: with `CLEAR_ON_FLUSH` = 0, `out_data` after a flush keeps the last main value.
